// File: rtl/gold_pkg.sv
`default_nettype none
// ============================================================================
// gold_pkg : shared constants and helpers for the GPS C/A Gold code generator
// Revision : 1.0
// ============================================================================
package gold_pkg;

    localparam int unsigned CHIP_LEN  = 1023;
    localparam logic [9:0]  LFSR_SEED = 10'h3FF;

    // Bit n-1 of a mask selects LFSR stage n (stage 1 = bit 0, stage 10 = bit 9).
    localparam logic [9:0]  G1_TAPS   = 10'h204;   // stages 3,10
    localparam logic [9:0]  G2_TAPS   = 10'h3A6;   // stages 2,3,6,8,9,10

    // G2 phase-select pairs, one byte per PRN: high nibble s1, low nibble s2.
    localparam logic [31:0][7:0] PRN_TABLE = {
        8'h49, 8'h38, 8'h27, 8'h16, 8'h8A, 8'h79, 8'h68, 8'h57, 8'h46,
        8'h13, 8'h69, 8'h58, 8'h47, 8'h36, 8'h25, 8'h14,
        8'h9A, 8'h89, 8'h78, 8'h67, 8'h56, 8'h34, 8'h23, 8'h3A,
        8'h29, 8'h18, 8'h2A, 8'h19, 8'h59, 8'h48, 8'h37, 8'h26
    };

    function automatic logic prn_valid(input logic [5:0] prn);
        return (prn >= 6'd1) && (prn <= 6'd32);
    endfunction

    function automatic logic [7:0] prn_taps(input logic [5:0] prn);
        logic [4:0] idx;
        idx = 5'(prn - 6'd1);
        return PRN_TABLE[idx];
    endfunction

    function automatic logic [9:0] lfsr_step(input logic [9:0] s, input logic [9:0] taps);
        return {s[8:0], ^(s & taps)};
    endfunction

    function automatic logic gold_bit(input logic [9:0] g1, input logic [9:0] g2,
                                      input logic [7:0] sel);
        logic [3:0] t1;
        logic [3:0] t2;
        t1 = sel[7:4] - 4'd1;
        t2 = sel[3:0] - 4'd1;
        return g1[9] ^ g2[t1] ^ g2[t2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/gold_chip_nco.sv
`default_nettype none
// ============================================================================
// gold_chip_nco : 32-bit phase accumulator; tick is the carry out while enabled
// Revision      : 1.0
// ============================================================================
module gold_chip_nco #(
    parameter logic [31:0] CHIP_FCW = 32'd3521873
) (
    input  logic sys_clk,
    input  logic reset_n,
    input  logic en,
    output logic tick
);

    logic [31:0] r_acc;
    logic [32:0] w_sum;

    assign w_sum = {1'b0, r_acc} + {1'b0, CHIP_FCW};
    assign tick  = en & w_sum[32];

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= w_sum[31:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/gold_code_gen.sv
`default_nettype none
// ============================================================================
// gold_code_gen : GPS C/A Gold code chip generator paced by a chip-rate NCO.
//                 Define GOLD_DYN_PRN_EN to add prn_sel (applied at code wrap).
// Revision      : 1.0
// ============================================================================
module gold_code_gen #(
    parameter int          PRN      = 1,
    parameter logic [31:0] CHIP_FCW = 32'd3521873
) (
    input  logic       sys_clk,
    input  logic       reset_n,
    input  logic       en,
`ifdef GOLD_DYN_PRN_EN
    input  logic [5:0] prn_sel,
`endif
    output logic       chip,
    output logic       chip_stb,
    output logic       epoch,
    output logic [9:0] chip_idx
);

    import gold_pkg::*;

    logic       w_tick;
    logic       w_wrap;
    logic       w_gold;
    logic [5:0] w_next_prn;
    logic [9:0] r_g1;
    logic [9:0] r_g2;
    logic [9:0] r_idx;
    logic [5:0] r_prn;

    gold_chip_nco #(
        .CHIP_FCW (CHIP_FCW)
    ) u_nco (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .en      (en),
        .tick    (w_tick)
    );

    assign w_wrap = (r_idx == 10'(CHIP_LEN - 1));
    assign w_gold = gold_bit(r_g1, r_g2, prn_taps(r_prn));

`ifdef GOLD_DYN_PRN_EN
    assign w_next_prn = prn_valid(prn_sel) ? prn_sel : r_prn;
`else
    assign w_next_prn = r_prn;
`endif

    // The chip presented on a strobe is the one computed from the LFSR state
    // before this tick's shift, so index and chip stay aligned.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_g1     <= LFSR_SEED;
            r_g2     <= LFSR_SEED;
            r_idx    <= '0;
            r_prn    <= 6'(PRN);
            chip     <= 1'b0;
            chip_idx <= '0;
            chip_stb <= 1'b0;
            epoch    <= 1'b0;
        end else begin
            chip_stb <= w_tick;
            epoch    <= w_tick & (r_idx == '0);
            if (w_tick) begin
                chip     <= w_gold;
                chip_idx <= r_idx;
                if (w_wrap) begin
                    r_idx <= '0;
                    r_g1  <= LFSR_SEED;
                    r_g2  <= LFSR_SEED;
                    r_prn <= w_next_prn;
                end else begin
                    r_idx <= r_idx + 10'd1;
                    r_g1  <= lfsr_step(r_g1, G1_TAPS);
                    r_g2  <= lfsr_step(r_g2, G2_TAPS);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gold_code_gen.sv
`default_nettype none
// ============================================================================
// tb_gold_code_gen : self-checking bench for gold_code_gen
// Revision         : 1.0
// ============================================================================
module tb_gold_code_gen;

    localparam logic [31:0]     FAST_FCW32 = 32'h4000_0000;
    localparam longint unsigned FAST_FCW   = 64'h4000_0000;
`ifdef GOLD_DYN_PRN_EN
    localparam int NSTB = 2056;
    localparam int NEP  = 3;
`else
    localparam int NSTB = 2046;
    localparam int NEP  = 2;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       en_on;
    logic [5:0] prn_sel;
    logic       chip, chip_stb, epoch;
    logic [9:0] chip_idx;
    logic       chip2, stb2, epoch2;
    logic [9:0] idx2;
    logic       chip3, stb3, epoch3;
    logic [9:0] idx3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gold_code_gen #(.PRN(1), .CHIP_FCW(FAST_FCW32)) dut (
        .sys_clk (clk), .reset_n (rst_n), .en (en),
`ifdef GOLD_DYN_PRN_EN
        .prn_sel (prn_sel),
`endif
        .chip (chip), .chip_stb (chip_stb), .epoch (epoch), .chip_idx (chip_idx)
    );

    gold_code_gen #(.PRN(2), .CHIP_FCW(FAST_FCW32)) dut2 (
        .sys_clk (clk), .reset_n (rst_n), .en (en_on),
`ifdef GOLD_DYN_PRN_EN
        .prn_sel (6'd0),
`endif
        .chip (chip2), .chip_stb (stb2), .epoch (epoch2), .chip_idx (idx2)
    );

    gold_code_gen #(.PRN(1)) dut3 (
        .sys_clk (clk), .reset_n (rst_n), .en (en_on),
`ifdef GOLD_DYN_PRN_EN
        .prn_sel (6'd0),
`endif
        .chip (chip3), .chip_stb (stb3), .epoch (epoch3), .chip_idx (idx3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference sequences from the LFSR output recurrences.
    bit ga [0:1039];
    bit gb [0:1039];
    bit gold1 [0:1022];
    bit gold2 [0:1022];

    task automatic build_tables();
        for (int n = 0; n < 10; n++) begin
            ga[n] = 1'b1;
            gb[n] = 1'b1;
        end
        for (int n = 0; n < 1030; n++) begin
            ga[n+10] = ga[n+7] ^ ga[n];
            gb[n+10] = gb[n+8] ^ gb[n+7] ^ gb[n+4] ^ gb[n+2] ^ gb[n+1] ^ gb[n];
        end
        for (int n = 0; n < 1023; n++) begin
            gold1[n] = ga[n] ^ gb[n+8] ^ gb[n+4];
            gold2[n] = ga[n] ^ gb[n+7] ^ gb[n+3];
        end
    endtask

    function automatic bit nco_carry(input longint unsigned k);
        return (((k + 1) * FAST_FCW) >> 32) != ((k * FAST_FCW) >> 32);
    endfunction

    // Model: chips are numbered by ticks since reset; outputs follow one cycle later.
    longint unsigned m_en_cnt;
    int              m_n;
    int              m_prn;
    logic            m_stb, m_epoch, m_chip;
    logic [9:0]      m_idx;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_en_cnt <= 0;
            m_n      <= 0;
            m_prn    <= 1;
            m_stb    <= 1'b0;
            m_epoch  <= 1'b0;
            m_chip   <= 1'b0;
            m_idx    <= '0;
        end else begin
            m_stb   <= 1'b0;
            m_epoch <= 1'b0;
            if (en) begin
                m_en_cnt <= m_en_cnt + 1;
                if (nco_carry(m_en_cnt)) begin
                    m_stb   <= 1'b1;
                    m_epoch <= (m_n % 1023 == 0);
                    m_idx   <= 10'(m_n % 1023);
                    m_chip  <= (m_prn == 2) ? gold2[m_n % 1023] : gold1[m_n % 1023];
                    m_n     <= m_n + 1;
`ifdef GOLD_DYN_PRN_EN
                    if (m_n % 1023 == 1022 && prn_sel >= 6'd1 && prn_sel <= 6'd32)
                        m_prn <= int'(prn_sel);
`endif
                end
            end
        end
    end

    always @(negedge clk)
        check("cycle_outputs", 32'({chip_stb, epoch, chip_idx, chip}),
              32'({m_stb, m_epoch, m_idx, m_chip}));

    logic [9:0] p2 = '0;
    int         c2 = 0;
    always @(negedge clk)
        if (rst_n && stb2 && c2 < 10) begin
            p2 <= {p2[8:0], chip2};
            c2 <= c2 + 1;
        end

    int d3_cnt = 0;
    int d3_cyc = 0;
    bit d3_done;
    always @(negedge clk) begin
        if (!rst_n) begin
            d3_cnt <= 0;
            d3_cyc <= 0;
        end else if (!d3_done) begin
            if (d3_cnt > 0) d3_cyc <= d3_cyc + 1;
            if (stb3) begin
                d3_cnt <= d3_cnt + 1;
                if (d3_cnt == 40) d3_done <= 1'b1;
            end
        end
    end

    task automatic wait_stb(output int cyc);
        cyc = 0;
        while (cyc == 0 || (!chip_stb && cyc < 40)) begin
            @(negedge clk);
            cyc++;
        end
        if (!chip_stb) check("stb_timeout", 32'(chip_stb), 32'd1);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cyc;
        int         n_ep;
        int         ep_at [0:3];
        int         n_diff;
        int         n_stb;
        int         n_chg;
        int         guard;
        logic [9:0] first10;
        logic [9:0] nxt10;
        logic [9:0] pin;
        logic       cap_chip;
        logic [9:0] cap_idx;
        bit         per1 [0:1022];

        build_tables();
        rst_n = 1'b0; en = 1'b0; en_on = 1'b0; prn_sel = 6'd0;
        n_ep = 0; n_diff = 0; first10 = '0; nxt10 = '0;
        for (int i = 0; i < 4; i++) ep_at[i] = 0;

        repeat (10) @(negedge clk);
        check("reset_outputs",  32'({chip_stb, epoch, chip_idx, chip}), 32'd0);
        check("reset_outputs2", 32'({stb2, epoch2, idx2, chip2, stb3, epoch3, idx3, chip3}), 32'd0);
        for (int i = 0; i < 10; i++) pin[9-i] = gold1[i];
        check("model_prn1_first10", 32'(pin), 32'(10'b1100100000));
        for (int i = 0; i < 10; i++) pin[9-i] = gold2[i];
        check("model_prn2_first10", 32'(pin), 32'(10'b1110010000));

        rst_n = 1'b1; en = 1'b1; en_on = 1'b1;

        for (int s = 1; s <= NSTB; s++) begin
            wait_stb(cyc);
            if (s == 1) begin
                check("first_stb_idx",   32'(chip_idx), 32'd0);
                check("first_stb_epoch", 32'(epoch),    32'd1);
            end else if (s <= 21) begin
                check("stb_period", 32'(cyc), 32'd4);
            end
            if (s == 301) check("resume_idx", 32'(chip_idx), 32'd300);
            if (epoch) begin
                if (n_ep < 4) ep_at[n_ep] = s;
                n_ep++;
            end
            if (s <= 10) first10 = {first10[8:0], chip};
            if (s == 10) check("prn1_first10", 32'(first10), 32'(10'b1100100000));
            if (s == 30) check("prn2_first10", 32'(p2), 32'(10'b1110010000));
            if (s <= 1023) per1[s-1] = chip;
            else if (s <= 2046 && chip !== per1[s-1024]) n_diff++;
            if (s == 300) begin
                cap_chip = chip;
                cap_idx  = chip_idx;
                en = 1'b0;
                n_stb = 0;
                n_chg = 0;
                repeat (50) begin
                    @(negedge clk);
                    if (chip_stb) n_stb++;
                    if (chip !== cap_chip || chip_idx !== cap_idx) n_chg++;
                end
                check("freeze_no_stb", 32'(n_stb), 32'd0);
                check("freeze_stable", 32'(n_chg), 32'd0);
                en = 1'b1;
            end
`ifdef GOLD_DYN_PRN_EN
            if (s == 1524) prn_sel = 6'd2;
            if (s > 2046) nxt10 = {nxt10[8:0], chip};
`endif
        end

        check("period2_identical", 32'(n_diff), 32'd0);
        check("epoch_count",  32'(n_ep),     32'(NEP));
        check("epoch_first",  32'(ep_at[0]), 32'd1);
        check("epoch_second", 32'(ep_at[1]), 32'd1024);
`ifdef GOLD_DYN_PRN_EN
        check("dyn_prn2_first10", 32'(nxt10), 32'(10'b1110010000));
        check("epoch_third",      32'(ep_at[2]), 32'd2047);
`endif

        guard = 0;
        while (!d3_done && guard < 50000) begin
            @(negedge clk);
            guard++;
        end
        check("default_rate_done", 32'(d3_done), 32'd1);
        n_checks++;
        if (d3_cyc < 48740 || d3_cyc > 48820) begin
            n_fail++;
            $display("FAIL default_rate_40_periods actual=%0d required=48740..48820", d3_cyc);
        end

        repeat (3) wait_stb(cyc);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1 check("midreset_outputs", 32'({chip_stb, epoch, chip_idx, chip}), 32'd0);
        #16 rst_n = 1'b1;
        wait_stb(cyc);
        check("restart_idx",   32'(chip_idx), 32'd0);
        check("restart_epoch", 32'(epoch),    32'd1);
        repeat (12) wait_stb(cyc);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
